cla_adder_pipe: RTL
===================

# cla_adder_pipe

Parametrised, two-stage pipelined carry-lookahead adder and the successor to the fixed 8-bit combinational CLA. Takes operands `a`, `b` and `c_in` through a valid/ready handshake, computes bit and group propagate/generate in stage 1, and resolves two-level lookahead carries and the sum in stage 2. It exposes the full carry vector for debug and verification. It sits between operand sources (ALU front end, accumulator loops) and result consumers that can apply backpressure.

## Interface
- `WIDTH`, 16: operand width. Must be a multiple of `GROUP`; otherwise elaboration fails.
- `GROUP`, 4: bits per first-level lookahead group. Legal values are 2, 4 and 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands are presented.
- `in_ready`  out  1  the stage-1 register can accept operands this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry in.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  the consumer accepts the result this cycle.
- `sum`  out  WIDTH  `(a + b + c_in) mod 2^WIDTH`.
- `c_out`  out  WIDTH+1  carry into each bit. `c_out[0]` = `c_in`; `c_out[WIDTH]` = final carry.
- `ovf`  out  1  signed overflow. Present only with `CLA_PIPE_OVF_EN`.

## Operation
- Stage 1 (on accept):
  - p = a ^ b, g = a & b, per bit.
  - Per group: P = AND of p; G = g[msb] | p[msb]&g[msb-1] | … .
  - Register p, g, group P/G and `c_in`, and set `s1_valid`.
- Stage 2:
  - Group carries: C[k+1] = G[k] | P[k]&C[k], expanded as a flat lookahead with no ripple chain. C[0] = `c_in`.
  - Bit carries inside each group come from that group's C[k].
  - sum[i] = p[i] ^ c_out[i].
  - Register `sum`, `c_out` and `ovf`, and set `out_valid`.
- Flow control:
  - advance2 = `s1_valid` & (!`out_valid` | `out_ready`).
  - `in_ready` = !`s1_valid` | advance2.
- Input accept = `in_valid` & `in_ready`. While `in_valid` is high, `a`, `b` and `c_in` must be held stable until accepted.
- Output hold: while `out_valid` & !`out_ready`, `sum`, `c_out` and `ovf` are held unchanged.
- Simultaneous events:
  - Accept into stage 1 and advance2 in the same cycle: stage 1 is overwritten with the new operands.
  - Output consume with no advance2: `out_valid` clears.
- Arithmetic wraps modulo 2^WIDTH. The carry-out is visible only on `c_out[WIDTH]`.

## Timing
- Latency is exactly 2 cycles from accept to `out_valid` when there is no backpressure.
- Throughput is 1 result per cycle.
- `in_ready` is combinational from `out_ready` (one-level path). No other input-to-output combinational path exists.
- Reset (async assert, synchronous-release usage):
  - `s1_valid` = 0, `out_valid` = 0, `in_ready` = 1.
  - `sum` = 0, `c_out` = 0, `ovf` = 0.
- Reset mid-operation discards all in-flight results. No output pulse occurs.

## Configuration
- `CLA_PIPE_OVF_EN` defined: `ovf` port exists and `ovf` = `c_out[WIDTH]` ^ `c_out[WIDTH-1]`, registered with `sum`.
- Not defined: the `ovf` port and its register are absent. All other behaviour is identical.

## Structure
- Package `cla_pkg` holds:
  - `CLA_GROUP_DEFAULT`.
  - Legal-GROUP check function.
  - Typedef `pg_t` as a {p, g} pair.
  - Function `num_groups(WIDTH, GROUP)`.
- Sub-module `cla_group` is a GROUP-bit combinational block: inputs p, g, c_in; outputs internal carries, group P and group G. It is instantiated WIDTH/GROUP times for group P/G and reused for bit-carry expansion in stage 2.

## Test plan
- WIDTH=16, GROUP=4, no backpressure: a=0x00FF, b=0x0001, c_in=0 -> after 2 cycles sum=0x0100, `c_out[16]`=0, `c_out[8:1]` all 1.
- Full propagate: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000 and `c_out` = all 17 bits set. With `CLA_PIPE_OVF_EN`, `ovf`=0.
- Signed overflow (`CLA_PIPE_OVF_EN`): a=0x7FFF, b=0x0001 -> sum=0x8000, `ovf`=1, `c_out[16]`=0.
- Backpressure: stream 4 back-to-back operations (0+1, 1+1, 2+1, 3+1) with `out_ready` low for cycles 3–5. Required:
  - `in_ready` drops once both stages are full.
  - The held output stays at 1.
  - Results emerge in order 1, 2, 3, 4 with none lost or duplicated.
- Reset mid-flight: assert `rst_n`=0 while `s1_valid`=1 and `out_valid`=1. Required:
  - Outputs go to 0 immediately.
  - After release, `in_ready`=1.
  - No stale result appears.
- Random sweep: 10k random a/b/c_in at WIDTH=32/GROUP=8 and WIDTH=8/GROUP=2 with random `out_ready`. Every `sum` and `c_out` matches a reference `a+b+c_in` model.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, constants and lookahead helper for the pipelined CLA
// Contents:
//   CLA_GROUP_DEFAULT  default bits per first-level lookahead group
//   pg_t               {p, g} pair for one bit position
//   group_is_legal()   true for the supported group sizes (2, 4, 8)
//   num_groups()       number of first-level groups for a given width
//   carry_into()       flat lookahead carry into lane 'top' from lanes below it
package cla_pkg;

    localparam int CLA_GROUP_DEFAULT = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic bit group_is_legal(input int group);
        return (group == 2) || (group == 4) || (group == 8);
    endfunction

    function automatic int num_groups(input int width, input int group);
        return width / group;
    endfunction

    // Sum-of-products form: g[top-1] | p[top-1]g[top-2] | ... | p[top-1:0]&cin.
    // 'run' holds the AND of all propagates above lane j, so no carry ripples
    // through an intermediate result; the loop only enumerates product terms.
    function automatic logic carry_into(input logic [63:0] p, input logic [63:0] g,
                                        input logic cin, input int top);
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        for (int j = 63; j >= 0; j--) begin
            if (j < top) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
        end
        return acc | (run & cin);
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// rtl/cla_adder_pipe_if.sv - operand/result handshake bundle for cla_adder_pipe
// Operand side : in_valid, in_ready, a, b, c_in
// Result side  : out_valid, out_ready, sum, c_out[WIDTH:0], ovf (CLA_PIPE_OVF_EN only)
// slave modport is the adder; master modport is the operand source / result sink.
interface cla_adder_pipe_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c_out;

`ifdef CLA_PIPE_OVF_EN
    logic             ovf;

    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, ovf);
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, ovf);
`else
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out);
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out);
`endif

endinterface

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit combinational lookahead block
// Ports:
//   p, g   [GROUP-1:0]  bit propagate / generate
//   c_in                 carry into the group's lowest bit
//   c      [GROUP-1:0]  carry into each bit of the group (c[0] = c_in)
//   grp_p, grp_g         group propagate / generate
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             c_in,
    output logic [GROUP-1:0] c,
    output logic             grp_p,
    output logic             grp_g
);

    always_comb begin
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = carry_into(64'(p), 64'(g), c_in, i);
        end
    end

    assign grp_p = &p;
    // Group generate is the carry out of the top bit with no carry in.
    assign grp_g = carry_into(64'(p), 64'(g), 1'b0, GROUP);

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined two-level carry-lookahead adder
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cla_adder_pipe_if.slave: operands in (valid/ready), sum + carry
//          vector out (valid/ready); ovf exists when CLA_PIPE_OVF_EN is defined
// Stage 1 registers bit and group propagate/generate; stage 2 resolves group
// carries, expands bit carries and registers sum/c_out.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_adder_pipe_if.slave        bus
);

    localparam int NG = num_groups(WIDTH, GROUP);

    if (!group_is_legal(GROUP)) begin : g_bad_group
        $error("cla_adder_pipe: GROUP must be 2, 4 or 8");
    end
    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
    end

    // ---------------- stage 1: bit and group propagate/generate ----------------
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    pg_t  [WIDTH-1:0] pg_d;
    logic [NG-1:0]    grp_p_d;
    logic [NG-1:0]    grp_g_d;
    logic [WIDTH-1:0] s1_unused_c;

    assign p_d = bus.a ^ bus.b;
    assign g_d = bus.a & bus.b;

    always_comb begin
        pg_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pg_d[i].p = p_d[i];
            pg_d[i].g = g_d[i];
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_s1_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p     (p_d[k*GROUP +: GROUP]),
            .g     (g_d[k*GROUP +: GROUP]),
            .c_in  (1'b0),
            .c     (s1_unused_c[k*GROUP +: GROUP]),
            .grp_p (grp_p_d[k]),
            .grp_g (grp_g_d[k])
        );
    end

    pg_t  [WIDTH-1:0] s1_pg;
    logic [NG-1:0]    s1_grp_p;
    logic [NG-1:0]    s1_grp_g;
    logic             s1_cin;
    logic             s1_valid;
    logic             out_valid_q;
    logic             in_ready;
    logic             accept;
    logic             advance2;

    // Stage 2 moves whenever the output slot is empty or being drained, so a
    // stalled consumer only blocks input once both stages are occupied.
    assign advance2     = s1_valid & (~out_valid_q | bus.out_ready);
    assign in_ready     = ~s1_valid | advance2;
    assign accept       = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pg    <= '0;
            s1_grp_p <= '0;
            s1_grp_g <= '0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pg    <= pg_d;
            s1_grp_p <= grp_p_d;
            s1_grp_g <= grp_g_d;
            s1_cin   <= bus.c_in;
        end else if (advance2) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- stage 2: carries and sum ----------------
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;
    logic [NG-1:0]    s2_unused_p;
    logic [NG-1:0]    s2_unused_g;
    logic [WIDTH:0]   c_d;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        s1_p = '0;
        s1_g = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_p[i] = s1_pg[i].p;
            s1_g[i] = s1_pg[i].g;
        end
    end

    // Every group carry is its own flat product-of-terms from c_in upward.
    always_comb begin
        grp_c = '0;
        for (int k = 0; k <= NG; k++) begin
            grp_c[k] = carry_into(64'(s1_grp_p), 64'(s1_grp_g), s1_cin, k);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_s2_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p     (s1_p[k*GROUP +: GROUP]),
            .g     (s1_g[k*GROUP +: GROUP]),
            .c_in  (grp_c[k]),
            .c     (bit_c[k*GROUP +: GROUP]),
            .grp_p (s2_unused_p[k]),
            .grp_g (s2_unused_g[k])
        );
    end

    assign c_d   = {grp_c[NG], bit_c};
    assign sum_d = s1_p ^ bit_c;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH:0]   c_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= '0;
        end else if (advance2) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
            c_out_q     <= c_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance2) begin
            ovf_q <= c_d[WIDTH] ^ c_d[WIDTH-1];
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
